jts16_obj_dispatch: RTL and testbench
=====================================

# jts16_obj_dispatch

Draw-command scheduler between the sprite line scanner and the sprite draw engines. It queues scanner draw commands in a small FIFO, hands each one to an idle draw engine with round-robin fairness, and back-pressures the scanner through `dr_busy`. It also flushes stale commands at every line start and reports when all drawing for the current line has finished.

## Interface
Parameters:
- `AW`, default 2: FIFO address width; depth = 2^AW entries.

Ports:
- `rst`  in  1  reset, asynchronous, active-high
- `clk`  in  1  clock
- `hstart`  in  1  line start pulse; flushes the queue
- `dr_start`  in  1  push strobe from the scanner, one cycle
- `dr_xpos`  in  9  command x position
- `dr_offset`  in  16  command ROM offset; MSB is the flip bit
- `dr_bank`  in  3  command bank
- `dr_prio`  in  2  command priority
- `dr_pal`  in  6  command palette
- `dr_busy`  out  1  queue full; scanner must not push
- `eng_start`  out  2  per-engine start pulse, one cycle
- `eng_busy`  in  2  per-engine busy flag
- `eng0_cmd`  out  36  engine 0 command word, held between starts
- `eng1_cmd`  out  36  engine 1 command word, held between starts
- `line_done`  out  1  queue empty and both engines idle since the last `hstart`
- `drop_cnt`  out  8  saturating count of dropped pushes

## Operation
- Command word layout: `{pal[35:30], prio[29:28], bank[27:25], offset[24:9], xpos[8:0]}`.
- Push: on `dr_start` with the queue not full, write the command at `wr_ptr`, then increment `wr_ptr` and `count`.
- A push while full, or in the same cycle as `hstart`, is discarded and increments `drop_cnt`. The counter saturates at 255 and clears only on reset.
- Engine `i` is eligible when `!eng_busy[i] && !eng_start[i]`. The start-cycle mask covers the one-cycle rise latency of the engine's busy flag.
- Dispatch: when `count != 0` and at least one engine is eligible, pop the head into `eng<i>_cmd` and pulse `eng_start[i]`.
- If both engines are eligible, pick the one not served last. A 1-bit `last` pointer tracks this; its reset value is 1, so engine 0 is served first.
- At most one dispatch per cycle.
- A simultaneous push and pop leaves `count` unchanged. Pointers wrap modulo depth.
- `hstart` resets `wr_ptr`, `rd_ptr` and `count` to 0 and suppresses any dispatch in that cycle.
  - Engines already started keep running.
  - `eng_cmd` registers keep their values.
- `line_done` is registered:
  - cleared on `hstart`;
  - set when `count==0`, `eng_start==0` and `eng_busy==0`, and no push occurs in that cycle;
  - cleared again by any later push.
- Reset values: `dr_busy=0`, `eng_start=0`, `eng0_cmd=0`, `eng1_cmd=0`, `line_done=0`, `drop_cnt=0`, pointers 0, `count=0`, `last=1`.
- Reset mid-line abandons all queued commands. Engines are not notified.

## Timing
- `dr_busy` is a registered flag equal to `count==2^AW`, valid in the cycle after the edge that filled the queue.
- Latency: a `dr_start` sampled at edge t into an empty queue produces `eng_start` high from edge t+1 to edge t+2. No same-cycle bypass.
- `eng<i>_cmd` changes only at the edge that raises `eng_start[i]`.
- Sustained throughput: one dispatch per cycle while an engine is eligible.
- `hstart` has priority over push and pop in the same cycle.

## Configuration
- `JTS16_OBJ_DUAL_EN` defined: two engines, round-robin arbitration as above.
- Not defined:
  - only engine 0 is used;
  - `eng_start[1]` and `eng1_cmd` are tied to 0;
  - `eng_busy[1]` is ignored, including in the `line_done` condition;
  - the `last` pointer is removed.

## Structure
- Shared package `jts16_obj_pkg` holds:
  - `OBJ_CMDW=36`;
  - field LSB/width constants for the command word;
  - a packed struct typedef for the command.
- Sub-module `jts16_obj_cmdfifo`:
  - parameter `AW`;
  - ports for push, pop, flush, `dout`, `full`, `empty`, `count`;
  - the flush/push priority rules above are implemented inside it.
- The top level contains the arbiter, the engine command registers, `line_done` and `drop_cnt`.

## Test plan
- Single push, both engines idle, xpos=0x10A, pal=0x2C → `eng_start=2'b01` exactly 2 edges later; `eng0_cmd[8:0]=0x10A`, `eng0_cmd[35:30]=0x2C`.
- Four back-to-back pushes with `eng_busy=2'b11` → `dr_busy=1` after the 4th. A 5th push is dropped, `drop_cnt=1`, and the queue contents are unchanged.
- Queue of 3, engines release busy together → dispatches alternate engine 0, 1, 0 on consecutive cycles, with no engine started twice before its busy flag rises.
- `hstart` coincident with a push while `count=2` → `count=0`, no `eng_start`, `drop_cnt` increments, `line_done=0` until the engines go idle.
- Push, dispatch, engine busy for 20 cycles then idle → `line_done` rises 1 cycle after `eng_busy` falls and drops on the next `hstart`.
- `JTS16_OBJ_DUAL_EN` undefined, 3 pushes → all go to engine 0 in order, `eng_start[1]` never asserts, and `eng_busy[1]=1` does not block `line_done`.

Source files
------------

// File: rtl/jts16_obj_pkg.sv
// rtl/jts16_obj_pkg.sv - sprite draw command word layout shared by the dispatch slice
package jts16_obj_pkg;

  localparam int OBJ_CMDW   = 36;

  localparam int XPOS_LSB   = 0;
  localparam int XPOS_W     = 9;
  localparam int OFFSET_LSB = 9;
  localparam int OFFSET_W   = 16;
  localparam int BANK_LSB   = 25;
  localparam int BANK_W     = 3;
  localparam int PRIO_LSB   = 28;
  localparam int PRIO_W     = 2;
  localparam int PAL_LSB    = 30;
  localparam int PAL_W      = 6;

  // offset MSB carries the horizontal flip bit
  typedef struct packed {
    logic [PAL_W-1:0]    pal;
    logic [PRIO_W-1:0]   prio;
    logic [BANK_W-1:0]   bank;
    logic [OFFSET_W-1:0] offset;
    logic [XPOS_W-1:0]   xpos;
  } obj_cmd_t;

endpackage

// File: rtl/jts16_obj_cmdfifo.sv
// rtl/jts16_obj_cmdfifo.sv - draw command FIFO; flush beats push/pop, full is registered
module jts16_obj_cmdfifo
  import jts16_obj_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  obj_cmd_t      din,
  output obj_cmd_t      dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  obj_cmd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jts16_obj_dispatch.sv
// rtl/jts16_obj_dispatch.sv - queues scanner draw commands and hands them to idle engines; JTS16_OBJ_DUAL_EN enables engine 1
module jts16_obj_dispatch
  import jts16_obj_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                hstart,
  input  logic                dr_start,
  input  logic [8:0]          dr_xpos,
  input  logic [15:0]         dr_offset,
  input  logic [2:0]          dr_bank,
  input  logic [1:0]          dr_prio,
  input  logic [5:0]          dr_pal,
  output logic                dr_busy,
  output logic [1:0]          eng_start,
  input  logic [1:0]          eng_busy,
  output logic [OBJ_CMDW-1:0] eng0_cmd,
  output logic [OBJ_CMDW-1:0] eng1_cmd,
  output logic                line_done,
  output logic [7:0]          drop_cnt
);

  obj_cmd_t    din;
  obj_cmd_t    head;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic [1:0]  elig;
  logic [1:0]  busy_used;
  logic        pop;
  logic        sel;

  assign din = {dr_pal, dr_prio, dr_bank, dr_offset, dr_xpos};

  jts16_obj_cmdfifo #(.AW(AW)) u_fifo (
    .rst   (rst),
    .clk   (clk),
    .flush (hstart),
    .push  (dr_start),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign dr_busy = full;

  // eng_start masks the engine for the cycle before its busy flag rises
`ifdef JTS16_OBJ_DUAL_EN
  logic last;

  assign elig      = ~eng_busy & ~eng_start;
  assign busy_used = eng_busy;
  assign sel       = (elig == 2'b11) ? ~last : elig[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      eng1_cmd <= '0;
    end else if (pop) begin
      last <= sel;
      if (sel) eng1_cmd <= head;
    end
  end
`else
  assign elig      = ~eng_busy & ~eng_start & 2'b01;
  assign busy_used = eng_busy & 2'b01;
  assign sel       = 1'b0;
  assign eng1_cmd  = '0;
`endif

  assign pop = !empty && !hstart && (elig != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_start <= 2'b00;
      eng0_cmd  <= '0;
    end else begin
      eng_start <= pop ? (sel ? 2'b10 : 2'b01) : 2'b00;
      if (pop && !sel) eng0_cmd <= head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line_done <= 1'b0;
    else if (hstart || dr_start)
      line_done <= 1'b0;
    else if (count == '0 && eng_start == 2'b00 && busy_used == 2'b00)
      line_done <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= 8'd0;
    else if (dr_start && (full || hstart) && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_jts16_obj_dispatch.sv
// tb/tb_jts16_obj_dispatch.sv - scoreboard bench for jts16_obj_dispatch
module tb_jts16_obj_dispatch;

`ifdef JTS16_OBJ_DUAL_EN
  localparam logic [1:0] REL = 2'b00;
`else
  localparam logic [1:0] REL = 2'b10;
`endif

  logic        rst, clk, hstart, dr_start;
  logic [8:0]  dr_xpos;
  logic [15:0] dr_offset;
  logic [2:0]  dr_bank;
  logic [1:0]  dr_prio;
  logic [5:0]  dr_pal;
  logic        dr_busy;
  logic [1:0]  eng_start, eng_busy;
  logic [35:0] eng0_cmd, eng1_cmd;
  logic        line_done;
  logic [7:0]  drop_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_drop = 0;
  logic [35:0] sbq[$];
  logic [35:0] mon_exp, mon_got;

  jts16_obj_dispatch #(.AW(2)) dut (
    .rst       (rst),
    .clk       (clk),
    .hstart    (hstart),
    .dr_start  (dr_start),
    .dr_xpos   (dr_xpos),
    .dr_offset (dr_offset),
    .dr_bank   (dr_bank),
    .dr_prio   (dr_prio),
    .dr_pal    (dr_pal),
    .dr_busy   (dr_busy),
    .eng_start (eng_start),
    .eng_busy  (eng_busy),
    .eng0_cmd  (eng0_cmd),
    .eng1_cmd  (eng1_cmd),
    .line_done (line_done),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard consumer: every dispatch must carry the oldest queued command
  always @(negedge clk) begin
    if (!rst && eng_start != 2'b00) begin
      n_chk++;
      if (eng_start == 2'b11) begin
        n_fail++;
        $display("FAIL dual_start: eng_start=%b required one-hot", eng_start);
      end else if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dispatch: eng_start=%b with no command outstanding", eng_start);
      end else begin
        mon_exp = sbq.pop_front();
        mon_got = eng_start[0] ? eng0_cmd : eng1_cmd;
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL dispatch_cmd: got %h required %h", mon_got, mon_exp);
        end
      end
`ifndef JTS16_OBJ_DUAL_EN
      n_chk++;
      if (eng_start[1] !== 1'b0 || eng1_cmd !== 36'd0) begin
        n_fail++;
        $display("FAIL eng1_tied: eng_start[1]=%b eng1_cmd=%h required 0", eng_start[1], eng1_cmd);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [35:0] c);
    {dr_pal, dr_prio, dr_bank, dr_offset, dr_xpos} = c;
  endtask

  task automatic push_many(input int n);
    logic [35:0] c;
    for (int i = 0; i < n; i++) begin
      c[31:0]  = $urandom;
      c[35:32] = 4'($urandom_range(0, 15));
      set_cmd(c);
      dr_start = 1'b1;
      sbq.push_back(c);
      tick();
    end
    dr_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hstart = 1'b0; dr_start = 1'b0; eng_busy = 2'b00;
    set_cmd(36'd0);
    repeat (3) tick();
    n_chk++;
    if ({dr_busy, eng_start, line_done, drop_cnt} !== 12'd0 || eng0_cmd !== 36'd0 || eng1_cmd !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b start=%b done=%b drop=%0d cmd0=%h cmd1=%h required all 0",
               dr_busy, eng_start, line_done, drop_cnt, eng0_cmd, eng1_cmd);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [35:0] c;
    c = {6'h2C, 2'd1, 3'd5, 16'h8123, 9'h10A};
    eng_busy = 2'b00;
    set_cmd(c);
    dr_start = 1'b1;
    sbq.push_back(c);
    tick();
    dr_start = 1'b0;
    n_chk++;
    if (eng_start !== 2'b00) begin
      n_fail++;
      $display("FAIL single_no_bypass: eng_start=%b required 00", eng_start);
    end
    tick();
    n_chk++;
    if (eng_start !== 2'b01 || eng0_cmd[8:0] !== 9'h10A || eng0_cmd[35:30] !== 6'h2C) begin
      n_fail++;
      $display("FAIL single_dispatch: start=%b xpos=%h pal=%h required 01/10a/2c",
               eng_start, eng0_cmd[8:0], eng0_cmd[35:30]);
    end
    tick();
    n_chk++;
    if (eng_start !== 2'b00) begin
      n_fail++;
      $display("FAIL single_pulse: eng_start=%b required 00", eng_start);
    end
  endtask

  task automatic test_full();
    logic [1:0] exp_start;
    eng_busy = 2'b11;
    push_many(4);
    n_chk++;
    if (dr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_busy: dr_busy=%b required 1", dr_busy);
    end
    set_cmd(36'hF_0BAD_BEEF);
    dr_start = 1'b1;
    tick();
    dr_start = 1'b0;
    exp_drop++;
    n_chk++;
    if (drop_cnt !== 8'(exp_drop) || dr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drop: drop_cnt=%0d busy=%b required %0d/1", drop_cnt, dr_busy, exp_drop);
    end
    eng_busy = REL;
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef JTS16_OBJ_DUAL_EN
      exp_start = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
`else
      exp_start = (k % 2 == 0) ? 2'b01 : 2'b00;
`endif
      n_chk++;
      if (eng_start !== exp_start) begin
        n_fail++;
        $display("FAIL drain_pattern[%0d]: eng_start=%b required %b", k, eng_start, exp_start);
      end
    end
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_empty: %0d commands outstanding required 0", sbq.size());
    end
  endtask

  task automatic test_hstart();
    eng_busy = 2'b11;
    push_many(2);
    set_cmd(36'h1_2345_6789);
    dr_start = 1'b1;
    hstart = 1'b1;
    tick();
    dr_start = 1'b0;
    hstart = 1'b0;
    exp_drop++;
    sbq.delete();
    n_chk++;
    if (drop_cnt !== 8'(exp_drop) || line_done !== 1'b0 || eng_start !== 2'b00 || dr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hstart_flush: drop=%0d done=%b start=%b busy=%b required %0d/0/00/0",
               drop_cnt, line_done, eng_start, dr_busy, exp_drop);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (eng_start !== 2'b00 || line_done !== 1'b0) begin
        n_fail++;
        $display("FAIL hstart_hold[%0d]: start=%b done=%b required 00/0", k, eng_start, line_done);
      end
    end
    eng_busy = REL;
    tick();
    n_chk++;
    if (line_done !== 1'b1 || eng_start !== 2'b00) begin
      n_fail++;
      $display("FAIL hstart_idle_done: done=%b start=%b required 1/00", line_done, eng_start);
    end
  endtask

  task automatic test_line_done();
    int b;
    eng_busy = REL;
    push_many(1);
    tick();
    n_chk++;
    if (eng_start == 2'b00) begin
      n_fail++;
      $display("FAIL ld_dispatch: eng_start=%b required a start", eng_start);
    end
    b = eng_start[1] ? 1 : 0;
    eng_busy[b] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_chk++;
      if (line_done !== 1'b0) begin
        n_fail++;
        $display("FAIL ld_while_busy[%0d]: line_done=%b required 0", k, line_done);
      end
    end
    eng_busy = REL;
    tick();
    n_chk++;
    if (line_done !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_rise: line_done=%b required 1", line_done);
    end
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    n_chk++;
    if (line_done !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_hstart_clear: line_done=%b required 0", line_done);
    end
  endtask

  task automatic test_engine1_blocked();
    eng_busy = 2'b10;
    push_many(3);
    for (int k = 0; k < 10; k++) begin
      tick();
      n_chk++;
      if (eng_start[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL eng1_busy_start[%0d]: eng_start=%b required bit1 0", k, eng_start);
      end
    end
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL eng0_order_drain: %0d commands outstanding required 0", sbq.size());
    end
`ifndef JTS16_OBJ_DUAL_EN
    n_chk++;
    if (line_done !== 1'b1) begin
      n_fail++;
      $display("FAIL eng1_ignored_done: line_done=%b required 1", line_done);
    end
`endif
  endtask

  task automatic test_drop_saturate();
    eng_busy = 2'b11;
    push_many(4);
    set_cmd(36'h0_0000_0001);
    dr_start = 1'b1;
    for (int k = 0; k < 260; k++) begin
      tick();
      if (exp_drop < 255) exp_drop++;
    end
    dr_start = 1'b0;
    n_chk++;
    if (drop_cnt !== 8'(exp_drop)) begin
      n_fail++;
      $display("FAIL drop_saturate: drop_cnt=%0d required %0d", drop_cnt, exp_drop);
    end
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    sbq.delete();
    eng_busy = REL;
    repeat (4) tick();
    n_chk++;
    if (drop_cnt !== 8'd255 || eng_start !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_hold_after_flush: drop=%0d start=%b required 255/00", drop_cnt, eng_start);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_hstart();
    test_line_done();
    test_engine1_blocked();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
